// File: rtl/bsg_clk_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bsg_clk_meter_pkg
// Brief    : Shared state encoding, width helper and result-struct macro for
//            the multi-channel clock meter.
// Revision : 1.0
// ============================================================================

`define BSG_CLK_METER_DECLARE_RESULT_S(chan_w, count_w) \
    typedef struct packed { \
        logic [(chan_w)-1:0]  chan; \
        logic                 sat; \
        logic [(count_w)-1:0] count; \
    } bsg_clk_meter_result_s

package bsg_clk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DRAIN   = 2'd3
    } meter_state_e;

    // Index width that never collapses to zero for a single channel.
    function automatic int lg_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_clk_meter_chan.sv
`default_nettype none
// ============================================================================
// Module   : bsg_clk_meter_chan
// Brief    : One metered channel: edge detect, saturating event counter,
//            end-of-window capture and sticky lo/hi fault flags.
// Revision : 1.0
// ============================================================================

module bsg_clk_meter_chan #(
    parameter int count_width_p = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     arm_i,
    input  logic                     measure_i,
    input  logic                     capture_i,
    input  logic                     toggle_i,
    input  logic [count_width_p-1:0] lo_thresh_i,
    input  logic [count_width_p-1:0] hi_thresh_i,
    input  logic                     clear_fault_i,
    output logic [count_width_p-1:0] count_o,
    output logic                     sat_o,
    output logic                     lo_fault_o,
    output logic                     hi_fault_o
);

    localparam logic [count_width_p-1:0] c_cnt_max = '1;

    logic                     prev_q, prev_d;
    logic [count_width_p-1:0] cnt_q, cnt_d;
    logic                     sat_q, sat_d;
    logic [count_width_p-1:0] cap_cnt_q, cap_cnt_d;
    logic                     cap_sat_q, cap_sat_d;
    logic                     lo_fault_q, lo_fault_d;
    logic                     hi_fault_q, hi_fault_d;
    logic                     edge_w;

    assign edge_w = toggle_i ^ prev_q;

    always_comb begin
        prev_d     = prev_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        cap_cnt_d  = cap_cnt_q;
        cap_sat_d  = cap_sat_q;
        lo_fault_d = clear_fault_i ? 1'b0 : lo_fault_q;
        hi_fault_d = clear_fault_i ? 1'b0 : hi_fault_q;

        if (arm_i) begin
            prev_d = toggle_i;
            cnt_d  = '0;
            sat_d  = 1'b0;
        end else if (measure_i) begin
            prev_d = toggle_i;
            // sat marks an event lost because the counter was already full
            if (edge_w) begin
                if (cnt_q == c_cnt_max) begin
                    sat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Capture sees this cycle's increment; a coincident clear loses to a set.
        if (capture_i) begin
            cap_cnt_d  = cnt_d;
            cap_sat_d  = sat_d;
            lo_fault_d = lo_fault_d | (cnt_d < lo_thresh_i);
            hi_fault_d = hi_fault_d | (cnt_d > hi_thresh_i) | sat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            prev_q     <= 1'b0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            cap_cnt_q  <= '0;
            cap_sat_q  <= 1'b0;
            lo_fault_q <= 1'b0;
            hi_fault_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            cap_cnt_q  <= cap_cnt_d;
            cap_sat_q  <= cap_sat_d;
            lo_fault_q <= lo_fault_d;
            hi_fault_q <= hi_fault_d;
        end
    end

    assign count_o    = cap_cnt_q;
    assign sat_o      = cap_sat_q;
    assign lo_fault_o = lo_fault_q;
    assign hi_fault_o = hi_fault_q;

endmodule

`default_nettype wire

// File: rtl/bsg_clk_meter_multi.sv
`default_nettype none
// ============================================================================
// Module   : bsg_clk_meter_multi
// Brief    : Multi-channel toggle-rate meter with programmable window,
//            threshold faults and a channel-serial valid/ready readout.
// Revision : 1.0
// ============================================================================

module bsg_clk_meter_multi
    import bsg_clk_meter_pkg::*;
#(
    parameter int  num_chan_p     = 4,
    parameter int  count_width_p  = 16,
    parameter int  window_width_p = 16,
    localparam int c_lg_chan      = lg_width(num_chan_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      start_i,
    input  logic                      continuous_i,
    input  logic [window_width_p-1:0] window_i,
    input  logic [num_chan_p-1:0]     toggle_i,
    input  logic [count_width_p-1:0]  lo_thresh_i,
    input  logic [count_width_p-1:0]  hi_thresh_i,
    input  logic                      clear_fault_i,
    output logic                      busy_o,
    output logic                      v_o,
    input  logic                      ready_i,
    output logic [c_lg_chan-1:0]      chan_o,
    output logic [count_width_p-1:0]  count_o,
    output logic                      sat_o,
    output logic [num_chan_p-1:0]     lo_fault_o,
    output logic [num_chan_p-1:0]     hi_fault_o
);

    localparam logic [c_lg_chan-1:0] c_last_chan = c_lg_chan'(num_chan_p - 1);

    `BSG_CLK_METER_DECLARE_RESULT_S(c_lg_chan, count_width_p);

    meter_state_e              state_q, state_d;
    logic [window_width_p-1:0] win_q, win_d;
    logic [c_lg_chan-1:0]      chan_q, chan_d;

    logic                      arm_w, measure_w, capture_w, hs_w;
    logic [count_width_p-1:0]  cap_count_w [num_chan_p];
    logic [num_chan_p-1:0]     cap_sat_w;
    bsg_clk_meter_result_s     result_w;

    assign arm_w     = (state_q == ARM);
    assign measure_w = (state_q == MEASURE);
    assign capture_w = measure_w && (win_q <= window_width_p'(1));
    assign hs_w      = (state_q == DRAIN) && ready_i;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        chan_d  = chan_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = ARM;
            end
            ARM: begin
                win_d   = (window_i == '0) ? window_width_p'(1) : window_i;
                state_d = MEASURE;
            end
            MEASURE: begin
                if (capture_w) begin
                    state_d = DRAIN;
                    chan_d  = '0;
                end else begin
                    win_d = win_q - 1'b1;
                end
            end
            DRAIN: begin
                if (hs_w) begin
                    if (chan_q == c_last_chan) begin
                        chan_d  = '0;
                        state_d = continuous_i ? ARM : IDLE;
                    end else begin
                        chan_d = chan_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            win_q   <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            chan_q  <= chan_d;
        end
    end

    for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
        bsg_clk_meter_chan #(
            .count_width_p (count_width_p)
        ) u_chan (
            .clk_i         (clk_i),
            .reset_n_i     (reset_n_i),
            .arm_i         (arm_w),
            .measure_i     (measure_w),
            .capture_i     (capture_w),
            .toggle_i      (toggle_i[c]),
            .lo_thresh_i   (lo_thresh_i),
            .hi_thresh_i   (hi_thresh_i),
            .clear_fault_i (clear_fault_i),
            .count_o       (cap_count_w[c]),
            .sat_o         (cap_sat_w[c]),
            .lo_fault_o    (lo_fault_o[c]),
            .hi_fault_o    (hi_fault_o[c])
        );
    end

    always_comb begin
        result_w.chan  = chan_q;
        result_w.sat   = cap_sat_w[chan_q];
        result_w.count = cap_count_w[chan_q];
    end

    assign busy_o  = (state_q != IDLE);
    assign v_o     = (state_q == DRAIN);
    assign chan_o  = result_w.chan;
    assign count_o = result_w.count;
    assign sat_o   = result_w.sat;

endmodule

`default_nettype wire
